// File: rtl/banked_ram_if.sv
// Request/response bus of banked_ram: one lane per port, packed by port index.
interface banked_ram_if #(
  parameter int DATA = 32,
  parameter int PORT = 2,
  parameter int ADDR = 6
);
  localparam int BE = DATA / 8;

  logic [PORT-1:0]           req;
  logic [PORT-1:0]           rw_;
  logic [PORT-1:0][ADDR-1:0] addr;
  logic [PORT-1:0][DATA-1:0] wdata;
  logic [PORT-1:0][BE-1:0]   be;
  logic [PORT-1:0]           ready;
  logic [PORT-1:0]           rvalid;
  logic [PORT-1:0][DATA-1:0] rdata;

  modport master (output req, rw_, addr, wdata, be, input ready, rvalid, rdata);
  modport slave  (input req, rw_, addr, wdata, be, output ready, rvalid, rdata);
endinterface

// File: rtl/banked_ram.sv
// Multi-port RAM built from BANK single-ported banks with per-bank round-robin arbitration.
// Optional memory-clear FSM enabled by defining BANKED_RAM_CLEAR_EN.
module banked_ram #(
  parameter int DATA   = 32,
  parameter int DEPTH  = 64,
  parameter int PORT   = 2,
  parameter int BANK   = 4,
  parameter int OUTREG = 0
) (
  input  logic          clk,
  input  logic          reset,
  banked_ram_if.slave   bus,
  input  logic          clr,
  output logic          busy
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int BSEL = $clog2(BANK);
  localparam int BE   = DATA / 8;
  localparam int ROWS = DEPTH / BANK;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW   = (BANK > 1) ? BSEL : 1;
  localparam int PW   = (PORT > 1) ? $clog2(PORT) : 1;

  logic [DATA-1:0]           mem [BANK][ROWS];
  logic [PW-1:0]             ptr [BANK];
  logic [PORT-1:0][ADDR-1:0] addr_w;
  logic [BW-1:0]             bank_of [PORT];
  logic [RW-1:0]             row_of [PORT];
  logic [BANK-1:0]           bank_act;
  logic [PW-1:0]             bank_gp [BANK];
  logic [PW-1:0]             idx_c;
  logic [PORT-1:0]           grant;
  logic                      clearing;
  logic [RW-1:0]             clr_row;
  logic [PORT-1:0]           vld_p0;
  logic [PORT-1:0][DATA-1:0] data_p0;

  assign addr_w = bus.addr;

  // Address decode: low bits pick the bank, the rest the row (wrapped per bank).
  always_comb begin
    for (int p = 0; p < PORT; p++) begin
      bank_of[p] = BW'(addr_w[p] % BANK);
      row_of[p]  = RW'((addr_w[p] / BANK) % ROWS);
    end
  end

  // Arbitration: each bank scans ports starting at its round-robin pointer.
  always_comb begin
    grant    = '0;
    bank_act = '0;
    idx_c    = '0;
    for (int b = 0; b < BANK; b++) begin
      bank_gp[b] = '0;
      for (int k = 0; k < PORT; k++) begin
        idx_c = PW'((32'(ptr[b]) + k) % PORT);
        if (!clearing && !bank_act[b] && bus.req[idx_c] && bank_of[idx_c] == BW'(b)) begin
          bank_act[b]  = 1'b1;
          bank_gp[b]   = idx_c;
          grant[idx_c] = 1'b1;
        end
      end
    end
  end

  assign bus.ready = grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < BANK; b++) ptr[b] <= '0;
    end else begin
      for (int b = 0; b < BANK; b++)
        if (bank_act[b]) ptr[b] <= PW'((32'(bank_gp[b]) + 1) % PORT);
    end
  end

  // Memory array: contents survive reset; clear sweeps one row of every bank per cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANK; b++) begin
      if (clearing) begin
        mem[b][clr_row] <= '0;
      end else if (bank_act[b] && !bus.rw_[bank_gp[b]]) begin
        for (int i = 0; i < BE; i++)
          if (bus.be[bank_gp[b]][i])
            mem[b][row_of[bank_gp[b]]][i*8 +: 8] <= bus.wdata[bank_gp[b]][i*8 +: 8];
      end
    end
  end

  // Stage p0: registered read at the grant edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= '0;
      data_p0 <= '0;
    end else begin
      for (int p = 0; p < PORT; p++) begin
        vld_p0[p] <= grant[p] & bus.rw_[p];
        if (grant[p] && bus.rw_[p]) data_p0[p] <= mem[bank_of[p]][row_of[p]];
      end
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [PORT-1:0]           vld_p1;
      logic [PORT-1:0][DATA-1:0] data_p1;

      // Stage p1: optional output register, data pre-zeroed when not valid.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_p1  <= '0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          for (int p = 0; p < PORT; p++) data_p1[p] <= vld_p0[p] ? data_p0[p] : '0;
        end
      end

      assign bus.rvalid = vld_p1;
      assign bus.rdata  = data_p1;
    end else begin : g_direct
      assign bus.rvalid = vld_p0;
      always_comb begin
        bus.rdata = '0;
        for (int p = 0; p < PORT; p++) bus.rdata[p] = vld_p0[p] ? data_p0[p] : '0;
      end
    end
  endgenerate

`ifdef BANKED_RAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t        state, state_nxt;
  logic [RW-1:0] clr_row_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clr_row <= '0;
    end else begin
      state   <= state_nxt;
      clr_row <= clr_row_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_row_nxt = clr_row;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt   = CLEAR;
          clr_row_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_row == RW'(ROWS - 1)) begin
          state_nxt   = IDLE;
          clr_row_nxt = '0;
        end else begin
          clr_row_nxt = clr_row + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clearing = (state == CLEAR);
  assign busy     = clearing;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign clearing   = 1'b0;
  assign clr_row    = '0;
  assign busy       = 1'b0;
`endif

endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 SHALL have parameter DATA, default 32: data width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 64: total words; multiple of BANK.
REQ-003 SHALL have parameter PORT, default 2: number of request ports; 1..8.
REQ-004 SHALL have parameter BANK, default 4: number of single-ported banks; power of 2, at least 1.
REQ-005 SHALL have parameter OUTREG, default 0: when 1, adds one output pipeline register.
REQ-006 SHALL have derived constants ADDR = clog2(DEPTH), BSEL = clog2(BANK), BE = DATA/8.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port req, input, PORT bits: access request per port.
REQ-010 SHALL have port rw_, input, PORT bits: 1 = read, 0 = write.
REQ-011 SHALL have port addr, input, PORT x ADDR bits: word address.
REQ-012 SHALL have port wdata, input, PORT x DATA bits: write data.
REQ-013 SHALL have port be, input, PORT x BE bits: byte enables for writes.
REQ-014 SHALL have port ready, output, PORT bits: request granted this cycle.
REQ-015 SHALL have port rvalid, output, PORT bits: read data valid.
REQ-016 SHALL have port rdata, output, PORT x DATA bits: read data.
REQ-017 SHALL have port clr, input, 1 bit: start a memory clear.
REQ-018 SHALL have port busy, output, 1 bit: clear in progress.

Function
REQ-019 SHALL decode bank = addr[BSEL-1:0] and row = addr[ADDR-1:BSEL]; when BANK = 1, bank is always 0.
REQ-020 SHALL let each bank perform at most one access (read or write) per cycle.
REQ-021 SHALL grant, per bank, one requesting port per cycle using round-robin; after a grant, that bank's pointer moves to (granted port + 1) mod PORT.
REQ-022 SHALL drive ready combinationally in the same cycle as req; ready = 0 whenever req = 0.
REQ-023 SHALL grant requests to different banks in the same cycle, with no cross-bank stall.
REQ-024 SHALL require an ungranted requester to hold req, rw_, addr, wdata and be stable until ready; ready is never withdrawn from a granted request within that cycle.
REQ-025 SHALL, on a granted write, update only the bytes whose be bit = 1 at the clock edge; be = 0 makes the access a granted no-op.
REQ-026 SHALL give granted reads a latency of 1 cycle when OUTREG = 0, or 2 cycles when OUTREG = 1, from the grant edge to rvalid = 1 for exactly 1 cycle.
REQ-027 SHALL drive rdata to 0 whenever rvalid = 0.
REQ-028 SHALL, for a read and a write to the same address granted in different cycles, return the data written before the read's grant edge (write-first across cycles).
REQ-029 SHALL handle address wrap inside each bank by modulo row indexing; no out-of-range access is possible.

Reset
REQ-030 SHALL, while reset = 0, clear asynchronously: all round-robin pointers to 0, rvalid to 0, rdata to 0, pipeline registers to 0, busy to 0, clear FSM to IDLE.
REQ-031 SHALL not reset memory contents.
REQ-032 SHALL discard reads in flight when reset is asserted, with no rvalid after reset release.

Configuration
REQ-033 SHALL, with macro BANKED_RAM_CLEAR_EN defined, implement a clear FSM with states IDLE -> CLEAR -> IDLE: clr = 1 in IDLE enters CLEAR; CLEAR writes 0 to row r of every bank in parallel, r = 0..DEPTH/BANK-1, one row per cycle; after the last row it returns to IDLE.
REQ-034 SHALL, with BANKED_RAM_CLEAR_EN defined, assert busy = 1 throughout CLEAR, force ready = 0 during CLEAR, still deliver reads granted before CLEAR, and ignore clr while in CLEAR.
REQ-035 SHALL, without BANKED_RAM_CLEAR_EN, keep the clr port but ignore it, tie busy to 0, and instantiate no FSM logic.

Verification
REQ-036 SHALL cover: default parameters, port 0 writes addr 5 = 0xDEADBEEF with be = 4'hF, then reads addr 5 -> rvalid 1 cycle after the read grant, rdata = 0xDEADBEEF.
REQ-037 SHALL cover: write 0x11223344 to addr 2, then write 0xAABBCCDD to addr 2 with be = 4'b0101 -> read returns 0x11BB33DD.
REQ-038 SHALL cover: ports 0 and 1 both continuously request bank 1 (addr 1 and addr 5) -> grants alternate 0,1,0,1; ready never set for both in one cycle.
REQ-039 SHALL cover: port 0 requests addr 0 and port 1 requests addr 1 in the same cycle -> both ready = 1 in the same cycle.
REQ-040 SHALL cover: OUTREG = 1, read granted at cycle N -> rvalid at N+2 only; reset asserted at N+1 -> no rvalid, rdata = 0.
REQ-041 SHALL cover: BANKED_RAM_CLEAR_EN defined, memory preloaded, pulse clr -> busy high for 16 cycles (DEPTH/BANK = 16), ready = 0 throughout, all addresses read back 0 afterwards.
